// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// Optional build macro DMEM_ARB_RR_EN selects round-robin conflict resolution
// (default build: fixed CPU priority).
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 13;
  localparam int unsigned DATA_W_DEF = 16;

  // IDLE: no command held; ISSUE: command register drives the memory this cycle
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way winner selection for the data-memory arbiter.
// A port whose grant is high this cycle is not eligible, so a held request is
// never issued twice. DMEM_ARB_RR_EN: conflicts go to the port not granted last;
// otherwise the CPU always wins a conflict.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   cpu_gnt,
  input  logic   dbg_req,
  input  logic   dbg_gnt,
`ifdef DMEM_ARB_RR_EN
  input  owner_e last_owner,
`endif
  output logic   win,
  output owner_e owner
);

  logic cpu_elig;
  logic dbg_elig;

  assign cpu_elig = cpu_req & ~cpu_gnt;
  assign dbg_elig = dbg_req & ~dbg_gnt;

  // Pick the winner among eligible requesters
  always_comb begin
    win   = cpu_elig | dbg_elig;
    owner = OWN_CPU;
    if (cpu_elig && dbg_elig) begin
`ifdef DMEM_ARB_RR_EN
      owner = (last_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
`else
      owner = OWN_CPU;
`endif
    end else if (dbg_elig) begin
      owner = OWN_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU and the debug/loader port.
// Arbitration in cycle N registers a command; cycle N+1 drives the memory and
// pulses the winner's grant; cycle N+2 returns read data with rvalid to the owner.
// Optional build macro DMEM_ARB_RR_EN enables round-robin on conflicts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  owner_e            cmd_owner_q, cmd_owner_d;
  logic              rd_pend_q, rd_pend_d;
  owner_e            rd_owner_q, rd_owner_d;

  logic   win;
  owner_e win_owner;

`ifdef DMEM_ARB_RR_EN
  owner_e last_q, last_d;
`endif

  dmem_arb_pick u_pick (
    .cpu_req    (cpu_req),
    .cpu_gnt    (cpu_gnt),
    .dbg_req    (dbg_req),
    .dbg_gnt    (dbg_gnt),
`ifdef DMEM_ARB_RR_EN
    .last_owner (last_q),
`endif
    .win        (win),
    .owner      (win_owner)
  );

  // Next command, read-tag and state; request fields are sampled only on a win
  always_comb begin
    state_d     = win ? ISSUE : IDLE;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_owner_d = cmd_owner_q;
    if (win) begin
      cmd_owner_d = win_owner;
      if (win_owner == OWN_DBG) begin
        cmd_we_d    = dbg_we;
        cmd_addr_d  = dbg_addr;
        cmd_wdata_d = dbg_wdata;
      end else begin
        cmd_we_d    = cpu_we;
        cmd_addr_d  = cpu_addr;
        cmd_wdata_d = cpu_wdata;
      end
    end
    rd_pend_d  = (state_q == ISSUE) & ~cmd_we_q;
    rd_owner_d = cmd_owner_q;
`ifdef DMEM_ARB_RR_EN
    last_d = win ? win_owner : last_q;
`endif
  end

  // State, command register and 1-deep read tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_owner_q <= OWN_CPU;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= OWN_CPU;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_owner_q <= cmd_owner_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Last winner; starts at debug so the CPU takes the first conflict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_DBG;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Memory strobes, grants and read responses decoded from the registers
  always_comb begin
    mem_en     = (state_q == ISSUE);
    mem_we     = mem_en & cmd_we_q;
    mem_addr   = cmd_addr_q;
    mem_wdata  = cmd_wdata_q;
    cpu_gnt    = mem_en & (cmd_owner_q == OWN_CPU);
    dbg_gnt    = mem_en & (cmd_owner_q == OWN_DBG);
    cpu_rvalid = rd_pend_q & (rd_owner_q == OWN_CPU);
    dbg_rvalid = rd_pend_q & (rd_owner_q == OWN_DBG);
    cpu_rdata  = mem_rdata;
    dbg_rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small synchronous memory model.
module tb_dmem_arbiter;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we;

  int n_checks;
  int n_fail;

  logic [DW-1:0] tb_mem [0:255];

  dmem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, preloaded while reset is held
  always @(posedge clk) begin
    if (rst) begin
      tb_mem[8'h03] <= 16'h00AB;
      tb_mem[8'h05] <= 16'h5555;
      tb_mem[8'h07] <= 16'h0777;
    end else if (mem_en) begin
      if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr[7:0]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req   = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // Reset state
    @(negedge clk);
    check_eq("rst_strobes", {28'd0, mem_en, mem_we, cpu_gnt, dbg_gnt}, 32'd0);
    check_eq("rst_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'd0);
    check_eq("rst_addr", {19'd0, mem_addr}, 32'd0);
    check_eq("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    step();
    step();
    rst = 1'b0;

    // Lone CPU read of 0x0003
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0003;
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    check_eq("rd_gnt", {30'd0, cpu_gnt, dbg_gnt}, 32'h2);
    check_eq("rd_mem_en_we", {30'd0, mem_en, mem_we}, 32'h2);
    check_eq("rd_mem_addr", {19'd0, mem_addr}, 32'h0003);
    check_eq("rd_early_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'd0);
    step();
    @(negedge clk);
    check_eq("rd_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'h2);
    check_eq("rd_rdata", {16'd0, cpu_rdata}, 32'h00AB);
    check_eq("rd_idle", {29'd0, mem_en, cpu_gnt, dbg_gnt}, 32'd0);

    // Debug write 0x1234 to 0x0010, then CPU read of 0x0010
    step();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 13'h0010; dbg_wdata = 16'h1234;
    step();
    dbg_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    @(negedge clk);
    check_eq("wr_gnt", {30'd0, cpu_gnt, dbg_gnt}, 32'h1);
    check_eq("wr_mem_en_we", {30'd0, mem_en, mem_we}, 32'h3);
    check_eq("wr_mem_addr", {19'd0, mem_addr}, 32'h0010);
    check_eq("wr_mem_wdata", {16'd0, mem_wdata}, 32'h1234);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    check_eq("wr_rd_gnt", {30'd0, cpu_gnt, dbg_gnt}, 32'h2);
    check_eq("wr_rd_en_we", {30'd0, mem_en, mem_we}, 32'h2);
    check_eq("wr_no_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'd0);
    step();
    @(negedge clk);
    check_eq("wr_rd_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'h2);
    check_eq("wr_rd_rdata", {16'd0, cpu_rdata}, 32'h1234);

    // Both requests held: fresh reset so the CPU takes the first conflict
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0003;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 13'h0010;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      check_eq($sformatf("alt_gnt_%0d", i), {30'd0, cpu_gnt, dbg_gnt},
               (i % 2 == 0) ? 32'h2 : 32'h1);
      check_eq($sformatf("alt_one_gnt_%0d", i), {31'd0, cpu_gnt & dbg_gnt}, 32'd0);
      check_eq($sformatf("alt_addr_%0d", i), {19'd0, mem_addr},
               (i % 2 == 0) ? 32'h0003 : 32'h0010);
      if (i > 0)
        check_eq($sformatf("alt_rvalid_%0d", i), {30'd0, cpu_rvalid, dbg_rvalid},
                 (i % 2 == 1) ? 32'h2 : 32'h1);
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    step();
    step();
    step();

    // CPU read in flight, reset asserted during its grant cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0003;
    step();
    cpu_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_strobes", {28'd0, mem_en, mem_we, cpu_gnt, dbg_gnt}, 32'd0);
    check_eq("mid_rst_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'd0);
    check_eq("mid_rst_addr", {19'd0, mem_addr}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("post_rst_quiet_%0d", i), {29'd0, mem_en, cpu_rvalid, dbg_rvalid},
               32'd0);
      step();
    end

    // CPU request held three cycles alone; address changes after the grant
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
    step();
    cpu_addr = 13'h0007;
    @(negedge clk);
    check_eq("hold_c0_en_gnt", {30'd0, mem_en, cpu_gnt}, 32'h3);
    check_eq("hold_c0_addr", {19'd0, mem_addr}, 32'h0005);
    step();
    @(negedge clk);
    check_eq("hold_c1_en_gnt", {30'd0, mem_en, cpu_gnt}, 32'd0);
    check_eq("hold_c1_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'h2);
    check_eq("hold_c1_rdata", {16'd0, cpu_rdata}, 32'h5555);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    check_eq("hold_c2_en_gnt", {30'd0, mem_en, cpu_gnt}, 32'h3);
    check_eq("hold_c2_addr", {19'd0, mem_addr}, 32'h0007);
    step();
    @(negedge clk);
    check_eq("hold_c3_rdata", {15'd0, cpu_rvalid, cpu_rdata}, {15'd0, 1'b1, 16'h0777});
    check_eq("hold_c3_en", {31'd0, mem_en}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
